bin2bcd_seq: RTL and testbench

//   Sequential binary-to-BCD converter (double-dabble, one bit per clock) that feeds D2STR-style decimal display stages.

---
 rtl/bin2bcd_seq.sv | 144 ++++++++++++++
 tb/tb_bin2bcd_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) with
// leading-zero blanking, fixed sign position and overflow dashes for display stages.
module bin2bcd_seq #(
  parameter int W      = 16,
  parameter int DIGITS = 6,
  parameter int SIGNED = 1,
  parameter int LZB    = 1
) (
  input  logic                  GCLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [W-1:0]          din,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int ND = DIGITS - SIGNED;
  localparam int NI = (W + 2) / 3;
  // Scratch also spans the displayed digits so formatting never indexes past it.
  localparam int NS = (ND > NI) ? ND : NI;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FORMAT
  } state_t;

  state_t              state_q;
  logic [W-1:0]        mag_q;
  logic                neg_q;
  logic [4*NS-1:0]     scratch_q;
  logic [CW-1:0]       cnt_q;
  logic                busy_q;
  logic                done_q;
  logic                ovf_q;
  logic [4*DIGITS-1:0] bcd_q;

  logic                negIn;
  logic [W-1:0]        magIn;
  logic [4*NS-1:0]     scratchAdj;
  logic [4*NS-1:0]     scratch_d;
  logic [W-1:0]        mag_d;
  logic [4*DIGITS-1:0] fmtBcd;
  logic                fmtOvf;
  logic                seenNz;

  // -2^(W-1) negates to itself, which is exactly 2^(W-1) read as unsigned.
  always_comb begin
    negIn = (SIGNED != 0) && din[W-1];
    magIn = negIn ? (~din + W'(1)) : din;
  end

  always_comb begin
    scratchAdj = scratch_q;
    for (int i = 0; i < NS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        scratchAdj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    {scratch_d, mag_d} = {scratchAdj, mag_q} << 1;
  end

  always_comb begin
    fmtOvf = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (i >= ND && scratch_q[4*i +: 4] != 4'd0) begin
        fmtOvf = 1'b1;
      end
    end
    fmtBcd = {DIGITS{4'hA}};
    seenNz = 1'b0;
    // Walk from the most significant displayed digit down; digit 0 is always numeric.
    for (int i = ND - 1; i >= 0; i--) begin
      if (scratch_q[4*i +: 4] != 4'd0) begin
        seenNz = 1'b1;
      end
      if (LZB != 0 && !seenNz && i != 0) begin
        fmtBcd[4*i +: 4] = 4'hA;
      end else begin
        fmtBcd[4*i +: 4] = scratch_q[4*i +: 4];
      end
    end
    if (SIGNED != 0) begin
      fmtBcd[4*(DIGITS-1) +: 4] = neg_q ? 4'hF : 4'hA;
    end
    if (fmtOvf) begin
      fmtBcd = {DIGITS{4'hF}};
    end
  end

  always_ff @(posedge GCLK) begin
    if (RST) begin
      state_q   <= IDLE;
      mag_q     <= '0;
      neg_q     <= 1'b0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      bcd_q     <= {DIGITS{4'hA}};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mag_q     <= magIn;
            neg_q     <= negIn;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_q <= scratch_d;
          mag_q     <= mag_d;
          cnt_q     <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= FORMAT;
          end
        end
        FORMAT: begin
          bcd_q   <= fmtBcd;
          ovf_q   <= fmtOvf;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: three parameterisations share clock and reset,
// expected results are queued at start and popped by per-instance done monitors.
module tb_bin2bcd_seq;

  logic        GCLK = 1'b0;
  logic        RST  = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [15:0] din0 = '0, din1 = '0, din2 = '0;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic        ovf0, ovf1, ovf2;
  logic [23:0] bcd0, bcd2;
  logic [15:0] bcd1;

  int checks = 0;
  int failures = 0;
  int pushCnt[3] = '{0, 0, 0};
  int doneCnt[3] = '{0, 0, 0};
  logic [24:0] q0[$], q1[$], q2[$];
  logic [24:0] e0, e1, e2;

  always #5 GCLK = ~GCLK;

  bin2bcd_seq #(.W(16), .DIGITS(6), .SIGNED(1), .LZB(1)) u0 (
    .GCLK(GCLK), .RST(RST), .start(start0), .din(din0),
    .busy(busy0), .done(done0), .ovf(ovf0), .bcd(bcd0));

  bin2bcd_seq #(.W(16), .DIGITS(4), .SIGNED(0), .LZB(1)) u1 (
    .GCLK(GCLK), .RST(RST), .start(start1), .din(din1),
    .busy(busy1), .done(done1), .ovf(ovf1), .bcd(bcd1));

  bin2bcd_seq #(.W(16), .DIGITS(6), .SIGNED(1), .LZB(0)) u2 (
    .GCLK(GCLK), .RST(RST), .start(start2), .din(din2),
    .busy(busy2), .done(done2), .ovf(ovf2), .bcd(bcd2));

  task automatic checkOutput(input string name, input logic [24:0] act, input logic [24:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Decimal reference: {ovf, nibbles}, built by repeated division rather than double-dabble.
  function automatic logic [24:0] model(input logic [15:0] v, input bit sgn, input int digits, input bit lzb);
    int m, nd;
    bit neg, seen;
    int d[6];
    logic [23:0] r;
    neg = sgn && v[15];
    m   = neg ? 65536 - int'(v) : int'(v);
    nd  = digits - (sgn ? 1 : 0);
    for (int i = 0; i < 6; i++) d[i] = 0;
    for (int i = 0; i < nd; i++) begin
      d[i] = m % 10;
      m    = m / 10;
    end
    r = '0;
    if (m != 0) begin
      for (int i = 0; i < digits; i++) r[4*i +: 4] = 4'hF;
      return {1'b1, r};
    end
    seen = 1'b0;
    for (int i = nd - 1; i >= 0; i--) begin
      if (d[i] != 0) seen = 1'b1;
      r[4*i +: 4] = (lzb && !seen && i != 0) ? 4'hA : 4'(d[i]);
    end
    if (sgn) r[4*(digits-1) +: 4] = neg ? 4'hF : 4'hA;
    return {1'b0, r};
  endfunction

  always @(negedge GCLK) begin
    if (done0) begin
      doneCnt[0]++;
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL unexpectedDone0: got bcd %h, expected no done", bcd0);
      end else begin
        e0 = q0.pop_front();
        checkOutput("result0", {ovf0, bcd0}, e0);
      end
    end
    if (done1) begin
      doneCnt[1]++;
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL unexpectedDone1: got bcd %h, expected no done", bcd1);
      end else begin
        e1 = q1.pop_front();
        checkOutput("result1", {ovf1, 8'h00, bcd1}, e1);
      end
    end
    if (done2) begin
      doneCnt[2]++;
      if (q2.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL unexpectedDone2: got bcd %h, expected no done", bcd2);
      end else begin
        e2 = q2.pop_front();
        checkOutput("result2", {ovf2, bcd2}, e2);
      end
    end
  end

  // Returns #1 after the edge that accepts start.
  task automatic applyStimulus(input int which, input logic [15:0] v, input logic [24:0] exp);
    @(posedge GCLK); #1;
    case (which)
      0: begin din0 = v; start0 = 1'b1; q0.push_back(exp); end
      1: begin din1 = v; start1 = 1'b1; q1.push_back(exp); end
      default: begin din2 = v; start2 = 1'b1; q2.push_back(exp); end
    endcase
    pushCnt[which]++;
    @(posedge GCLK); #1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
  endtask

  task automatic waitDone(input int which);
    bit seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(posedge GCLK); #1;
      seen = (which == 0) ? done0 : (which == 1) ? done1 : done2;
    end
    if (!seen) begin
      checks++; failures++;
      $display("[TB] FAIL timeout%0d: got no done in 40 cycles, expected done", which);
    end
  endtask

  task automatic runOne(input int which, input logic [15:0] v, input logic [24:0] exp);
    applyStimulus(which, v, exp);
    waitDone(which);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] v;
    repeat (3) @(posedge GCLK);
    #1;
    checkOutput("resetBusy", 25'(busy0), 25'd0);
    checkOutput("resetDone", 25'(done0), 25'd0);
    checkOutput("resetOut", {ovf0, bcd0}, 25'h0AAAAAA);
    RST = 1'b0;

    // Zero with exact latency, then a back-to-back start in the done cycle
    // with a stray start mid-conversion that must be ignored.
    applyStimulus(0, 16'd0, 25'h0AAAAA0);
    repeat (16) @(posedge GCLK);
    #1;
    checkOutput("latBusyEdgeW", 25'(busy0), 25'd1);
    checkOutput("latNoDoneEdgeW", 25'(done0), 25'd0);
    @(posedge GCLK); #1;
    checkOutput("latDone", 25'(done0), 25'd1);
    checkOutput("latBusyLow", 25'(busy0), 25'd0);
    din0 = 16'hFB2E; start0 = 1'b1; q0.push_back(25'h0FA1234); pushCnt[0]++;
    @(posedge GCLK); #1;
    start0 = 1'b0;
    repeat (5) @(posedge GCLK);
    #1;
    din0 = 16'd999; start0 = 1'b1;
    @(posedge GCLK); #1;
    start0 = 1'b0;
    repeat (10) @(posedge GCLK);
    #1;
    checkOutput("b2bNoDoneEarly", 25'(done0), 25'd0);
    @(posedge GCLK); #1;
    checkOutput("b2bDone", 25'(done0), 25'd1);
    repeat (20) @(posedge GCLK);

    runOne(0, 16'd1234, 25'h0AA1234);
    runOne(0, 16'h8000, 25'h0F32768);
    runOne(0, 16'h7FFF, 25'h0A32767);
    runOne(0, 16'hFFFF, 25'h0FAAAA1);
    runOne(0, 16'd10,   25'h0AAAA10);

    runOne(1, 16'd9999,  25'h0009999);
    runOne(1, 16'd12345, 25'h100FFFF);
    runOne(1, 16'd65535, 25'h100FFFF);
    runOne(1, 16'd0,     25'h000AAA0);
    runOne(1, 16'd1000,  25'h0001000);
    runOne(1, 16'd10000, 25'h100FFFF);

    runOne(2, 16'd42,    25'h0A00042);
    runOne(2, 16'hFFF9,  25'h0F00007);
    runOne(2, 16'd0,     25'h0A00000);

    // Reset after the eighth shift aborts without a done pulse.
    @(posedge GCLK); #1;
    din0 = 16'd1234; start0 = 1'b1;
    @(posedge GCLK); #1;
    start0 = 1'b0;
    repeat (8) @(posedge GCLK);
    #1;
    RST = 1'b1;
    @(posedge GCLK); #1;
    checkOutput("abortBusy", 25'(busy0), 25'd0);
    checkOutput("abortOut", {ovf0, bcd0}, 25'h0AAAAAA);
    RST = 1'b0;
    repeat (25) @(posedge GCLK);
    runOne(0, 16'd42, 25'h0AAAA42);

    for (int n = 0; n < 8; n++) begin
      v = 16'($urandom);
      runOne(0, v, model(v, 1'b1, 6, 1'b1));
      v = 16'($urandom);
      runOne(1, v, model(v, 1'b0, 4, 1'b1));
    end

    repeat (5) @(posedge GCLK);
    #1;
    checkOutput("doneCount0", 25'(doneCnt[0]), 25'(pushCnt[0]));
    checkOutput("doneCount1", 25'(doneCnt[1]), 25'(pushCnt[1]));
    checkOutput("doneCount2", 25'(doneCnt[2]), 25'(pushCnt[2]));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
